// File: rtl/uart_tx_fifo.sv
// Small generic FIFO: registered pointers and occupancy count, combinational head read.
// Latency: a pushed word is visible at rd_dat the cycle after the push edge.
// Backpressure: wr_rdy = !full; a push is refused while full even if a pop happens that cycle.
module uart_tx_fifo_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    output logic                     wr_rdy,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign wr_rdy = (count != CW'(DEPTH));
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_en && (count != '0);
    assign rd_dat = mem[rd_ptr];

    // Storage array; contents need no reset, only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Buffered 8N1 UART transmitter: byte FIFO feeding a start/8 data/stop serialiser.
// Latency: a byte pushed into an empty idle block drives the start bit after the next edge.
// Backpressure: tx_ready = !full; frames drain back-to-back with no idle gap.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          UART_TX,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [7:0]    head;
    logic          bit_end;
    logic          pop;

    assign bit_end = (baud_cnt == BW'(CLKS_PER_BIT - 1));
    // The serialiser pops only when it loads the shift register: from IDLE, or at the
    // end of a stop bit so the next start bit follows with no gap.
    assign pop     = (fifo_count != '0) && ((state == IDLE) || ((state == STOP) && bit_end));
    assign busy    = (state != IDLE) || (fifo_count != '0);

    uart_tx_fifo_buf #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (tx_valid),
        .wr_dat (tx_data),
        .wr_rdy (tx_ready),
        .rd_en  (pop),
        .rd_dat (head),
        .count  (fifo_count)
    );

    // Serialiser FSM with registered line output; each bit lasts CLKS_PER_BIT cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            UART_TX  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    UART_TX  <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        shift   <= head;
                        UART_TX <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        UART_TX  <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            UART_TX <= 1'b1;
                            state   <= STOP;
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            UART_TX <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift   <= head;
                            UART_TX <= 1'b0;
                            state   <= START;
                        end else begin
                            state   <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    UART_TX <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A line decoder samples mid-bit and records each received byte with its start cycle.
// Inputs are driven and outputs sampled on the falling edge.
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       UART_TX;
    logic       busy;
    logic [2:0] fifo_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] byte_q[$];
    int         start_q[$];
    int         mon_s;
    logic [7:0] mon_d;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .UART_TX    (UART_TX),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Receiver model: detect start, sample each bit at its midpoint.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && UART_TX === 1'b0) begin
                mon_s = cyc;
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    mon_d[i] = UART_TX;
                end
                repeat (CPB) @(negedge clk);
                if (UART_TX === 1'b1) begin
                    byte_q.push_back(mon_d);
                    start_q.push_back(mon_s);
                end
            end
        end
    end

    task automatic push1(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int t;
        t = 0;
        while (busy && t < bound) begin
            @(negedge clk);
            t++;
        end
        chk(tag, busy, 0);
        repeat (2) @(negedge clk);
    endtask

    // exp holds up to 8 bytes, first-transmitted byte in bits [7:0].
    task automatic check_bytes(input string tag, input int n, input logic [63:0] exp, input int first);
        chk($sformatf("%s_nbytes", tag), byte_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < byte_q.size()) begin
                chk($sformatf("%s_byte%0d", tag, i), byte_q[i], exp[8*i +: 8]);
            end
        end
        if (start_q.size() > 0) begin
            chk($sformatf("%s_first_start", tag), start_q[0], first);
        end
        for (int i = 1; i < start_q.size(); i++) begin
            chk($sformatf("%s_gap%0d", tag, i), start_q[i] - start_q[i-1], FRAME);
        end
        byte_q.delete();
        start_q.delete();
    endtask

    initial begin
        int         k;
        int         i;
        int         t;
        int         trans;
        logic       r;
        logic       prev;
        logic       seen_full;
        logic [7:0] e55;
        logic [39:0] got_f;
        logic [39:0] exp_f;

        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_tx", UART_TX, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);

        // Single byte: cycle-exact waveform.
        e55 = 8'h55;
        push1(8'h55);
        k = cyc;
        chk("t1_count_k", fifo_count, 1);
        chk("t1_tx_k", UART_TX, 1);
        for (int j = 1; j <= FRAME; j++) begin
            int b;
            @(negedge clk);
            b = (j - 1) / CPB;
            got_f[j-1] = UART_TX;
            exp_f[j-1] = (b == 0) ? 1'b0 : ((b <= 8) ? e55[b-1] : 1'b1);
            if (j == 1)     chk("t1_count_k1", fifo_count, 0);
            if (j == FRAME) chk("t1_busy_k40", busy, 1);
        end
        @(negedge clk);
        chk("t1_busy_k41", busy, 0);
        chk("t1_frame", got_f, exp_f);
        repeat (2) @(negedge clk);
        check_bytes("t1", 1, 64'h55, k + 1);

        // Back-to-back frames.
        push1(8'h30);
        k = cyc;
        push1(8'h31);
        push1(8'h32);
        wait_idle("t2_idle", 300);
        check_bytes("t2", 3, 64'h32_31_30, k + 1);

        // Full FIFO with tx_valid held; data changes while stalled must be ignored.
        push1(8'h41);
        k = cyc;
        repeat (5) @(negedge clk);
        i = 0;
        t = 0;
        seen_full = 1'b0;
        while (i < 5 && t < 200) begin
            tx_valid = 1'b1;
            r        = tx_ready;
            tx_data  = r ? (8'h42 + 8'(i)) : 8'hEE;
            @(negedge clk);
            t++;
            if (r) i++;
            if (i == 4 && !seen_full) begin
                seen_full = 1'b1;
                chk("t3_count_full", fifo_count, 4);
                chk("t3_ready_full", tx_ready, 0);
            end
        end
        tx_valid = 1'b0;
        chk("t3_accepted", i, 5);
        wait_idle("t3_idle", 400);
        check_bytes("t3", 6, 64'h46_45_44_43_42_41, k + 1);

        // Push on the STOP-end pop edge with two bytes queued.
        push1(8'h50);
        k = cyc;
        push1(8'h51);
        push1(8'h52);
        chk("t4_count_q", fifo_count, 2);
        while (cyc < k + FRAME && cyc < k + 200) @(negedge clk);
        chk("t4_count_pre", fifo_count, 2);
        push1(8'h53);
        chk("t4_count_post", fifo_count, 2);
        chk("t4_ready_post", tx_ready, 1);
        chk("t4_tx_start", UART_TX, 0);
        wait_idle("t4_idle", 400);
        check_bytes("t4", 4, 64'h53_52_51_50, k + 1);

        // Reset during data bit 3 of 0xA5 with two bytes queued.
        push1(8'hA5);
        k = cyc;
        push1(8'h11);
        push1(8'h22);
        while (cyc < k + 18 && cyc < k + 200) @(negedge clk);
        chk("t5_bit3", UART_TX, 0);
        chk("t5_count_pre", fifo_count, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5_tx", UART_TX, 1);
        chk("t5_count", fifo_count, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ready", tx_ready, 1);
        trans = 0;
        prev  = UART_TX;
        repeat (100) begin
            @(negedge clk);
            if (UART_TX !== prev) trans++;
            prev = UART_TX;
        end
        chk("t5_transitions", trans, 0);
        chk("t5_busy_after", busy, 0);
        byte_q.delete();
        start_q.delete();

        // Loopback through the receiver model.
        push1(8'h00);
        k = cyc;
        push1(8'hFF);
        push1(8'h7E);
        wait_idle("t6_idle", 300);
        check_bytes("t6", 3, 64'h7E_FF_00, k + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered 8N1 UART transmitter. It serialises bytes onto UART_TX at a configurable bit period.
- Pairs with the team's UART receiver as the sending end of the same serial link.
- Upstream logic pushes bytes through a valid/ready handshake into a small FIFO.
- The serialiser drains the FIFO back-to-back with no idle gap between frames.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per serial bit (12 MHz / 115200); legal range ≥2.
- FIFO_DEPTH, 4, byte entries in the transmit FIFO; power of 2, ≥2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_data  input  8  byte to transmit; sampled when tx_valid && tx_ready.
- tx_valid  input  1  upstream offers tx_data.
- tx_ready  output  1  FIFO can accept a byte; equals !full.
- UART_TX  output  1  serial line, registered; idle high.
- busy  output  1  high while the FIFO is non-empty or a frame is in progress.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes held in the FIFO, excluding the byte being shifted.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high on port reset.
- Reset values:
  - UART_TX=1, tx_ready=1, busy=0, fifo_count=0.
  - State=IDLE; bit and baud counters =0.
  - FIFO pointers =0; FIFO contents undefined.
- Push:
  - Occurs at an edge where tx_valid && tx_ready; tx_data is written at the write pointer.
  - While full, tx_ready=0 and tx_valid is ignored. No push-when-full, even if a pop happens in the same cycle.
  - A simultaneous push and pop leaves fifo_count unchanged.
- Pop: performed only by the serialiser, on the edge where it loads its shift register.
- Serialiser FSM (baud counter counts 0..CLKS_PER_BIT-1; a bit ends at the edge where the counter is CLKS_PER_BIT-1):
  - IDLE: UART_TX=1. If fifo_count>0, pop the head into the shift register, set UART_TX<=0, go to START, counter<=0.
  - START: hold 0 for CLKS_PER_BIT cycles. At bit end, UART_TX<=shift[0], go to DATA, bit index<=0.
  - DATA: each bit lasts CLKS_PER_BIT cycles, LSB first, shifting right. After bit index 7 ends, UART_TX<=1 and go to STOP.
  - STOP: hold 1 for CLKS_PER_BIT cycles. At bit end:
    - if fifo_count>0, pop, UART_TX<=0, go to START (zero-gap back-to-back);
    - else go to IDLE.
- Framing and latency:
  - Each frame is exactly 10*CLKS_PER_BIT cycles low-to-stop-end.
  - From the push edge k with the FIFO empty and FSM in IDLE, UART_TX goes low after edge k+1. The byte is popped at edge k+1, so fifo_count returns to 0 at k+1.
- busy = (state!=IDLE) || (fifo_count!=0); registered or combinational are both allowed, but it must be 0 exactly one cycle after STOP ends with the FIFO empty.
- Pointers: wrap modulo FIFO_DEPTH; full when fifo_count==FIFO_DEPTH; empty when 0.
- Reset mid-frame: the frame is truncated, UART_TX=1 after the reset edge, the FIFO is flushed, and nothing resumes.
- Held tx_valid: tx_data changing while tx_valid=1 and tx_ready=0 has no effect. No sticky state is held.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Single byte: push 0x55 at edge k.
  - UART_TX is 0 for cycles k+1..k+4, then 1,0,1,0,1,0,1,0, each held 4 cycles.
  - Stop bit is 1 for 4 cycles; busy drops at k+41.
- Back-to-back: push 0x30, 0x31, 0x32 on consecutive cycles.
  - Three frames of 40 cycles each with no idle cycles between them.
  - Decoded bytes are 0x30, 0x31, 0x32 in order.
- Full FIFO: with the serialiser mid-frame, push 5 bytes with tx_valid held high.
  - 4 are accepted; fifo_count=4 and tx_ready=0.
  - The 5th is accepted only after the next pop (STOP end); all 6 bytes are transmitted in order.
- Simultaneous push/pop: push timed on the STOP-end edge with fifo_count=2.
  - fifo_count stays 2 and tx_ready stays 1.
- Reset mid-frame: assert reset for 1 cycle during DATA bit 3 of 0xA5, with 2 bytes queued.
  - UART_TX=1, fifo_count=0, busy=0 after the edge; no further transitions for 100 cycles.
- Loopback: drive UART_TX into the team's UART receiver configured for the same bit period and send 0x00, 0xFF, 0x7E.
  - The receiver reports identical bytes.
